// File: rtl/feature_pingpong_buf.sv
// feature_pingpong_buf: two-buffer, multi-bank ping-pong store for CNN feature maps.
// The producer fills the write buffer and commits it with wr_last; the consumer reads
// the oldest committed buffer and frees it with rd_release. Ownership swaps by pointer
// toggling, so no data is copied.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   wr_valid/ready    producer beat handshake; wr_addr/wr_data/wr_be select word/lanes
//   wr_last           final beat of a buffer, commits it to the consumer side
//   rd_en/rd_addr     read request into the readable buffer (2-cycle latency)
//   rd_avail/rd_len   a committed buffer is readable / its accepted-beat count
//   rd_release        consumer done with the readable buffer
//   rd_valid/rd_data  read response, all lanes; rd_data holds when rd_valid=0
//   err               sticky protocol error (beat or request while not allowed)
module feature_pingpong_buf #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16384,
  parameter int unsigned ADDR_W    = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [NUM_BANKS*DATA_W-1:0]   wr_data,
  input  logic [NUM_BANKS-1:0]          wr_be,
  input  logic                          wr_last,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  output logic                          rd_avail,
  output logic [ADDR_W:0]               rd_len,
  input  logic                          rd_release,
  output logic                          rd_valid,
  output logic [NUM_BANKS*DATA_W-1:0]   rd_data,
  output logic                          err
);

  localparam int unsigned CNT_W     = ADDR_W + 1;
  localparam int unsigned BUS_W     = NUM_BANKS * DATA_W;
  localparam int unsigned RAM_DEPTH = 2 << ADDR_W;

  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic [CNT_W-1:0] r_wcnt;
  logic [CNT_W-1:0] r_len [2];
  logic             r_wr_ready;
  logic             r_rd_avail;
  logic [CNT_W-1:0] r_rd_len;
  logic             r_rd_v1;
  logic             r_rd_valid;
  logic [BUS_W-1:0] r_rd_data;
  logic             r_err;

  logic             w_wr_acc;
  logic             w_commit;
  logic             w_rd_acc;
  logic             w_rel;
  logic [CNT_W-1:0] w_wcnt_inc;
  logic [1:0]       w_count_nxt;
  logic             w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_len_nxt [2];
  logic             w_err_evt;
  logic [BUS_W-1:0] w_ram_q;

  assign w_wr_acc   = wr_valid & r_wr_ready & ~reset;
  assign w_commit   = w_wr_acc & wr_last;
  assign w_rd_acc   = rd_en & r_rd_avail & ~reset;
  assign w_rel      = rd_release & r_rd_avail;
  assign w_wcnt_inc = (r_wcnt == CNT_W'(DEPTH)) ? r_wcnt : r_wcnt + CNT_W'(1);
  assign w_err_evt  = (wr_valid & ~r_wr_ready) | ((rd_en | rd_release) & ~r_rd_avail);

  // Next committed count, read pointer and lengths; status outputs are registered from these.
  always_comb begin
    w_count_nxt  = r_count;
    w_rd_ptr_nxt = r_rd_ptr;
    w_len_nxt[0] = r_len[0];
    w_len_nxt[1] = r_len[1];
    if (w_commit && !w_rel) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_commit && w_rel) begin
      w_count_nxt = r_count - 2'd1;
    end
    if (w_rel) begin
      w_rd_ptr_nxt = ~r_rd_ptr;
    end
    if (w_commit) begin
      w_len_nxt[r_wr_ptr] = w_wcnt_inc;
    end
  end

  // Buffer ownership, beat counting, status and error tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_wcnt     <= '0;
      r_len[0]   <= '0;
      r_len[1]   <= '0;
      r_wr_ready <= 1'b1;
      r_rd_avail <= 1'b0;
      r_rd_len   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_len[0]   <= w_len_nxt[0];
      r_len[1]   <= w_len_nxt[1];
      r_wr_ready <= (w_count_nxt != 2'd2);
      r_rd_avail <= (w_count_nxt != 2'd0);
      r_rd_len   <= w_len_nxt[w_rd_ptr_nxt];
      r_err      <= r_err | w_err_evt;
      if (w_commit) begin
        r_wcnt   <= '0;
        r_wr_ptr <= ~r_wr_ptr;
      end else if (w_wr_acc) begin
        r_wcnt   <= w_wcnt_inc;
      end
    end
  end

  // Per-bank RAM holding both buffers; the buffer pointer is the top address bit,
  // so the read buffer is captured with each request.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] r_mem [RAM_DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
      if (w_wr_acc && wr_be[b]) begin
        r_mem[{r_wr_ptr, wr_addr}] <= wr_data[b*DATA_W +: DATA_W];
      end
      if (w_rd_acc) begin
        r_q <= r_mem[{r_rd_ptr, rd_addr}];
      end
    end

    assign w_ram_q[b*DATA_W +: DATA_W] = r_q;
  end

  // Read response pipeline: RAM output register, then output stage holding last data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_v1    <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_v1    <= w_rd_acc;
      r_rd_valid <= r_rd_v1;
      if (r_rd_v1) begin
        r_rd_data <= w_ram_q;
      end
    end
  end

  assign wr_ready = r_wr_ready;
  assign rd_avail = r_rd_avail;
  assign rd_len   = r_rd_len;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign err      = r_err;

endmodule

// File: tb/tb_feature_pingpong_buf.sv
// Directed bench for feature_pingpong_buf: table-driven cycle vectors plus
// hand-written sequences for reset, fill/readback, full-buffer and error cases.
module tb_feature_pingpong_buf;

  localparam int unsigned NB    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16384;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [NB*DW-1:0]  wr_data;
  logic [NB-1:0]     wr_be;
  logic              wr_last;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic              rd_avail;
  logic [AW:0]       rd_len;
  logic              rd_release;
  logic              rd_valid;
  logic [NB*DW-1:0]  rd_data;
  logic              err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  feature_pingpong_buf #(
    .NUM_BANKS(NB), .DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be), .wr_last(wr_last),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_avail(rd_avail), .rd_len(rd_len),
    .rd_release(rd_release), .rd_valid(rd_valid), .rd_data(rd_data), .err(err)
  );

  typedef struct {
    logic        wv;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        wlast;
    logic        ren;
    logic [13:0] raddr;
    logic        rrel;
    logic        e_wr_ready;
    logic        e_rd_avail;
    logic [14:0] e_len;
    logic        e_valid;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; wr_last = 1'b0;
    rd_en = 1'b0; rd_addr = '0; rd_release = 1'b0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wbeat(input logic [13:0] a, input logic [31:0] d, input logic [3:0] be,
                       input logic last);
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_be = be; wr_last = last;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    chk({tag, "_rd_avail"}, 32'(rd_avail), 32'd0);
    chk({tag, "_rd_len"},   32'(rd_len),   32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
  endtask

  initial begin
    // Partial-lane update then simultaneous commit/release with reads spanning the swap.
    vecs[0]  = '{1, 3, 32'h11223344, 4'hF, 0, 0, 0, 0, 1, 1, 5, 0, 32'h10101010};
    vecs[1]  = '{1, 3, 32'hAABBCCDD, 4'h5, 1, 0, 0, 0, 0, 1, 5, 0, 32'h10101010};
    vecs[2]  = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 1, 1, 1, 2, 0, 32'h10101010};
    vecs[3]  = '{0, 0, 32'h0,        4'h0, 0, 1, 3, 0, 1, 1, 2, 0, 32'h10101010};
    vecs[4]  = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 0, 1, 1, 2, 1, 32'h11BB33DD};
    vecs[5]  = '{1, 0, 32'h40404040, 4'hF, 0, 1, 3, 0, 1, 1, 2, 0, 32'h11BB33DD};
    vecs[6]  = '{1, 1, 32'h41414141, 4'hF, 0, 1, 3, 0, 1, 1, 2, 1, 32'h11BB33DD};
    vecs[7]  = '{1, 2, 32'h42424242, 4'hF, 1, 1, 3, 1, 1, 1, 3, 1, 32'h11BB33DD};
    vecs[8]  = '{0, 0, 32'h0,        4'h0, 0, 1, 1, 0, 1, 1, 3, 1, 32'h11BB33DD};
    vecs[9]  = '{0, 0, 32'h0,        4'h0, 0, 1, 0, 0, 1, 1, 3, 1, 32'h41414141};
    vecs[10] = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 0, 1, 1, 3, 1, 32'h40404040};
    vecs[11] = '{0, 0, 32'h0,        4'h0, 0, 0, 0, 0, 1, 1, 3, 0, 32'h40404040};

    // Reset state
    do_reset();
    tick();
    chk_clear("rst");
    chk("rst_rd_data", rd_data, 32'h0);

    // Fill 16 beats, commit, read back with 2-cycle latency
    for (int i = 0; i < 16; i++) begin
      wbeat(14'(i), {4{8'(i)}}, 4'hF, (i == 15));
      tick();
      if (i == 14) chk("fill_no_avail_early", 32'(rd_avail), 32'd0);
    end
    idle();
    chk("fill_rd_avail", 32'(rd_avail), 32'd1);
    chk("fill_rd_len",   32'(rd_len),   32'd16);
    chk("fill_wr_ready", 32'(wr_ready), 32'd1);
    for (int c = 0; c < 18; c++) begin
      rd_en   = (c < 16);
      rd_addr = 14'(c);
      tick();
      chk($sformatf("rd_valid_%0d", c), 32'(rd_valid), 32'((c >= 1) && (c <= 16)));
      if (c >= 1 && c <= 16) chk($sformatf("rd_data_%0d", c - 1), rd_data, {4{8'(c - 1)}});
    end
    idle();
    rd_release = 1'b1;
    tick();
    idle();
    chk("rel_rd_avail", 32'(rd_avail), 32'd0);
    chk("rel_err", 32'(err), 32'd0);

    // Two committed buffers (8 then 5 beats) fill the block
    for (int i = 0; i < 8; i++) begin
      wbeat(14'(i), {4{8'(8'h10 + i)}}, 4'hF, (i == 7));
      tick();
    end
    chk("a_rd_len", 32'(rd_len), 32'd8);
    chk("a_wr_ready", 32'(wr_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wbeat(14'(i), {4{8'(8'h80 + i)}}, 4'hF, (i == 4));
      tick();
    end
    idle();
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    chk("full_rd_len", 32'(rd_len), 32'd8);
    chk("full_err_clean", 32'(err), 32'd0);
    wbeat(0, 32'hFFFFFFFF, 4'hF, 1'b1);
    tick();
    idle();
    chk("drop_err", 32'(err), 32'd1);
    chk("drop_wr_ready", 32'(wr_ready), 32'd0);
    chk("drop_rd_len", 32'(rd_len), 32'd8);
    rd_en = 1'b1; rd_addr = 0; rd_release = 1'b1;
    tick();
    idle();
    chk("full_rel_len", 32'(rd_len), 32'd5);
    chk("full_rel_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    chk("drop_data_valid", 32'(rd_valid), 32'd1);
    chk("drop_data_unchanged", rd_data, 32'h10101010);

    // Table-driven vectors
    for (int k = 0; k < 12; k++) begin
      wr_valid = vecs[k].wv; wr_addr = vecs[k].waddr; wr_data = vecs[k].wdata;
      wr_be = vecs[k].wbe; wr_last = vecs[k].wlast;
      rd_en = vecs[k].ren; rd_addr = vecs[k].raddr; rd_release = vecs[k].rrel;
      tick();
      chk($sformatf("v%0d_wr_ready", k), 32'(wr_ready), 32'(vecs[k].e_wr_ready));
      chk($sformatf("v%0d_rd_avail", k), 32'(rd_avail), 32'(vecs[k].e_rd_avail));
      chk($sformatf("v%0d_rd_len", k),   32'(rd_len),   32'(vecs[k].e_len));
      chk($sformatf("v%0d_rd_valid", k), 32'(rd_valid), 32'(vecs[k].e_valid));
      chk($sformatf("v%0d_rd_data", k),  rd_data,       vecs[k].e_data);
    end
    idle();

    // Reads/releases with nothing committed
    do_reset();
    tick();
    chk_clear("rst2");
    rd_en = 1'b1; rd_release = 1'b1;
    tick();
    idle();
    chk("empty_err", 32'(err), 32'd1);
    chk("empty_rd_avail", 32'(rd_avail), 32'd0);
    tick();
    chk("empty_no_valid", 32'(rd_valid), 32'd0);
    wbeat(5, 32'h77777777, 4'hF, 1'b0);
    tick();
    wbeat(6, 32'h78787878, 4'hF, 1'b1);
    tick();
    idle();
    chk("empty_ptr_len", 32'(rd_len), 32'd2);
    chk("empty_err_sticky", 32'(err), 32'd1);
    rd_en = 1'b1; rd_addr = 6;
    tick();
    idle();
    tick();
    chk("empty_ptr_data", rd_data, 32'h78787878);

    // Reset with two reads in flight and both buffers committed
    wbeat(0, 32'h01020304, 4'hF, 1'b1);
    tick();
    idle();
    chk("pre_rst_full", 32'(wr_ready), 32'd0);
    rd_en = 1'b1; rd_addr = 5;
    tick();
    rd_addr = 6;
    tick();
    idle();
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_clear("mid_rst");
    chk("mid_rst_rd_data", rd_data, 32'h0);
    tick();
    chk("post_rst_valid", 32'(rd_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
